seg_disp_arb: RTL and testbench

//  Owns the 8-digit seven-segment display. Two requesters (e.g. keyboard path, counter path)

---
 rtl/seg_pkg.sv | 16 +
 rtl/seg_hex_enc.sv | 11 +
 rtl/seg_disp_arb.sv | 157 +++++++++++++++
 tb/tb_seg_disp_arb.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_pkg;

  typedef enum logic [1:0] {IDLE, ACCEPT, HOLD} state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-high a..g,dp patterns for hex digits 0..F
  localparam logic [7:0] FONT [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  localparam logic [7:0] SEG_ZERO = ~FONT[0];

endpackage

// File: rtl/seg_hex_enc.sv
// Nibble to active-low seven-segment pattern (dp always dark).
module seg_hex_enc
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);

  assign seg_o = ~FONT[nib_i];

endmodule

// File: rtl/seg_disp_arb.sv
// Two-requester round-robin owner of an 8-digit hex display with hold and scroll.
// Optional leading-zero blanking: define SEG_DISP_ZERO_BLANK_EN.
module seg_disp_arb
  import seg_pkg::*;
#(
  parameter int unsigned CLK_NUM  = 5000000,
  parameter int unsigned HOLD_NUM = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        ack1,
  input  logic        scroll_en,
  input  logic        blank,
  output logic        busy,
  output logic [7:0]  o_seg0,
  output logic [7:0]  o_seg1,
  output logic [7:0]  o_seg2,
  output logic [7:0]  o_seg3,
  output logic [7:0]  o_seg4,
  output logic [7:0]  o_seg5,
  output logic [7:0]  o_seg6,
  output logic [7:0]  o_seg7
);

  localparam int unsigned CW = (CLK_NUM  > 1) ? $clog2(CLK_NUM)  : 1;
  localparam int unsigned HW = (HOLD_NUM > 1) ? $clog2(HOLD_NUM) : 1;

  state_e         state_q, state_d;
  logic           busy_q, ack0_q, ack0_d, ack1_q, ack1_d;
  logic           last_q, last_d;
  logic [31:0]    disp_q, disp_d;
  logic [2:0]     off_q, off_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [7:0]     seg_q [8];
  logic [7:0]     seg_d [8];
  logic [7:0]     enc   [8];
  logic [3:0]     nib   [8];
  logic [2:0]     idx   [8];
  logic [7:0]     dark;
  logic           grant;

  always_comb begin
    state_d = state_q;
    hold_d  = '0;
    last_d  = last_q;
    disp_d  = disp_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    grant   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // Contention goes to whoever did not win last time
          grant   = (req0 && req1) ? ~last_q : req1;
          state_d = ACCEPT;
          last_d  = grant;
          disp_d  = grant ? data1 : data0;
          ack0_d  = ~grant;
          ack1_d  = grant;
        end
      end
      ACCEPT: state_d = HOLD;
      HOLD: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HW'(HOLD_NUM - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    off_d = '0;
    if (scroll_en) begin
      off_d = off_q;
      if (cnt_q == CW'(CLK_NUM - 1)) begin
        off_d = off_q + 3'd1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Blanking is decided per nibble position, so it rotates along with the digit
  always_comb begin
    dark = '0;
`ifdef SEG_DISP_ZERO_BLANK_EN
    dark[7] = (disp_q[31:28] == 4'h0);
    for (int unsigned j = 1; j < 7; j++) begin
      dark[7-j] = dark[8-j] && (disp_q[4*(7-j) +: 4] == 4'h0);
    end
`endif
    for (int unsigned k = 0; k < 8; k++) begin
      idx[k]   = 3'(k) + off_q;
      nib[k]   = disp_q[{idx[k], 2'b00} +: 4];
      seg_d[k] = dark[idx[k]] ? SEG_OFF : enc[k];
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_enc
    seg_hex_enc u_enc (
      .nib_i (nib[g]),
      .seg_o (enc[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      last_q  <= 1'b1;
      disp_q  <= '0;
      off_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      for (int unsigned k = 0; k < 8; k++) begin
`ifdef SEG_DISP_ZERO_BLANK_EN
        seg_q[k] <= (k == 0) ? SEG_ZERO : SEG_OFF;
`else
        seg_q[k] <= SEG_ZERO;
`endif
      end
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      last_q  <= last_d;
      disp_q  <= disp_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      for (int unsigned k = 0; k < 8; k++) seg_q[k] <= seg_d[k];
    end
  end

  assign ack0   = ack0_q;
  assign ack1   = ack1_q;
  assign busy   = busy_q;
  assign o_seg0 = blank ? SEG_OFF : seg_q[0];
  assign o_seg1 = blank ? SEG_OFF : seg_q[1];
  assign o_seg2 = blank ? SEG_OFF : seg_q[2];
  assign o_seg3 = blank ? SEG_OFF : seg_q[3];
  assign o_seg4 = blank ? SEG_OFF : seg_q[4];
  assign o_seg5 = blank ? SEG_OFF : seg_q[5];
  assign o_seg6 = blank ? SEG_OFF : seg_q[6];
  assign o_seg7 = blank ? SEG_OFF : seg_q[7];

endmodule

// File: tb/tb_seg_disp_arb.sv
// Directed plus randomized bench for seg_disp_arb against a countdown/arithmetic model.
module tb_seg_disp_arb;

  localparam int unsigned CN = 4;
  localparam int unsigned HN = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0 = 1'b0, req1 = 1'b0, scroll_en = 1'b0, blank = 1'b0;
  logic [31:0] data0 = '0, data1 = '0;
  logic        ack0, ack1, busy;
  logic [7:0]  o_seg0, o_seg1, o_seg2, o_seg3, o_seg4, o_seg5, o_seg6, o_seg7;
  logic [7:0]  seg_o [8];

  always #5 clk = ~clk;

  seg_disp_arb #(.CLK_NUM(CN), .HOLD_NUM(HN)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .scroll_en(scroll_en), .blank(blank), .busy(busy),
    .o_seg0(o_seg0), .o_seg1(o_seg1), .o_seg2(o_seg2), .o_seg3(o_seg3),
    .o_seg4(o_seg4), .o_seg5(o_seg5), .o_seg6(o_seg6), .o_seg7(o_seg7)
  );

  assign seg_o[0] = o_seg0;
  assign seg_o[1] = o_seg1;
  assign seg_o[2] = o_seg2;
  assign seg_o[3] = o_seg3;
  assign seg_o[4] = o_seg4;
  assign seg_o[5] = o_seg5;
  assign seg_o[6] = o_seg6;
  assign seg_o[7] = o_seg7;

  logic [7:0] font [16] = '{
    8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
    8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
  };

  int unsigned total = 0, passed = 0;

  // Reference state: busy cycles remaining, last winner, shown word, scroll position
  int unsigned m_left, m_off, m_cnt;
  bit          m_last, e_ack0, e_ack1;
  logic [31:0] m_disp;
  logic [7:0]  m_seg [8];

  function automatic logic [7:0] digit_exp(int unsigned k, logic [31:0] w, int unsigned off);
    int unsigned n;
    logic [3:0]  nb;
    n  = (k + off) % 8;
    nb = w[4*n +: 4];
`ifdef SEG_DISP_ZERO_BLANK_EN
    if (n != 0 && (w >> (4*n)) == 32'd0) return 8'hFF;
`endif
    return ~font[nb];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_left = 0; m_last = 1'b1; m_disp = '0; m_off = 0; m_cnt = 0;
    e_ack0 = 1'b0; e_ack1 = 1'b0;
    for (int unsigned k = 0; k < 8; k++) m_seg[k] = digit_exp(k, 32'd0, 0);
  endtask

  task automatic model_step();
    bit g;
    for (int unsigned k = 0; k < 8; k++) m_seg[k] = digit_exp(k, m_disp, m_off);
    e_ack0 = 1'b0; e_ack1 = 1'b0;
    if (m_left == 0 && (req0 || req1)) begin
      g      = (req0 && req1) ? ~m_last : req1;
      m_disp = g ? data1 : data0;
      m_last = g;
      if (g) e_ack1 = 1'b1; else e_ack0 = 1'b1;
      m_left = HN + 1;
    end else if (m_left > 0) begin
      m_left--;
    end
    if (scroll_en) begin
      if (m_cnt == CN - 1) begin
        m_cnt = 0;
        m_off = (m_off + 1) % 8;
      end else begin
        m_cnt++;
      end
    end else begin
      m_cnt = 0; m_off = 0;
    end
  endtask

  task automatic check_all();
    chk("ack0", 32'(ack0), 32'(e_ack0));
    chk("ack1", 32'(ack1), 32'(e_ack1));
    chk("busy", 32'(busy), 32'(m_left > 0));
    for (int unsigned k = 0; k < 8; k++)
      chk($sformatf("seg%0d", k), 32'(seg_o[k]), 32'(blank ? 8'hFF : m_seg[k]));
  endtask

  // One clock: advance model on the edge, compare 1 time unit later, retire acked requests
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    if (e_ack0) req0 = 1'b0;
    if (e_ack1) req1 = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] t2 [8];
    t2 = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F};

    // Reset state
    model_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_all();
    chk("rst_seg0", 32'(o_seg0), 32'h03);
    @(negedge clk) rst = 1'b1;
    repeat (10) tick();

    // Single accept from requester 0
    data0 = 32'h76543210; req0 = 1'b1;
    repeat (8) tick();
    for (int unsigned k = 0; k < 8; k++) chk($sformatf("t2_seg%0d", k), 32'(seg_o[k]), 32'(t2[k]));

    // Both requesting out of reset, then round-robin again
    @(negedge clk) rst = 1'b0;
    model_reset();
    req0 = 1'b1; req1 = 1'b1; data0 = $urandom; data1 = $urandom;
    #1 check_all();
    @(negedge clk) rst = 1'b1;
    repeat (12) tick();
    req0 = 1'b1; req1 = 1'b1; data0 = $urandom; data1 = $urandom;
    repeat (12) tick();

    // Request arriving during HOLD waits for IDLE
    req0 = 1'b1; data0 = $urandom;
    tick(); tick();
    req1 = 1'b1; data1 = $urandom;
    repeat (8) tick();

    // Scrolling
    req0 = 1'b1; data0 = 32'h76543210;
    repeat (6) tick();
    scroll_en = 1'b1;
    repeat (40) tick();
    scroll_en = 1'b0;
    repeat (3) tick();

    // Blank
    blank = 1'b1;
    repeat (3) tick();
    chk("blank_seg3", 32'(o_seg3), 32'hFF);
    blank = 1'b0;
    tick();

    // Reset in the middle of HOLD
    req0 = 1'b1; data0 = 32'h89ABCDEF;
    tick(); tick();
    #2 rst = 1'b0;
    model_reset();
    req0 = 1'b0;
    #1 check_all();
    chk("midrst_busy", 32'(busy), 32'h0);
    @(negedge clk) rst = 1'b1;
    repeat (3) tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1'b1; data0 = $urandom >> (4 * $urandom_range(0, 7));
      end
      if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1'b1; data1 = $urandom >> (4 * $urandom_range(0, 7));
      end
      if ($urandom_range(0, 15) == 0) scroll_en = ~scroll_en;
      if ($urandom_range(0, 19) == 0) blank = ~blank;
      tick();
    end

    req0 = 1'b0; req1 = 1'b0; scroll_en = 1'b0; blank = 1'b0;
    repeat (6) tick();

`ifdef SEG_DISP_ZERO_BLANK_EN
    req0 = 1'b1; data0 = 32'h000000A5;
    repeat (3) tick();
    chk("zb_seg0", 32'(o_seg0), 32'h49);
    chk("zb_seg1", 32'(o_seg1), 32'h11);
    chk("zb_seg2", 32'(o_seg2), 32'hFF);
    chk("zb_seg7", 32'(o_seg7), 32'hFF);
    repeat (4) tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
